// File: rtl/dispatch_queue.sv
// In-order dispatch queue between Rename and Dispatch; uop payload is an opaque UOP_W-bit word.
// Optional macro DISP_QUEUE_BYPASS_EN: empty-queue uops reach disp_uop in the same cycle.
module dispatch_queue #(
  parameter int DEPTH = 8,
  parameter int UOP_W = 32,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [UOP_W-1:0] instr_uop,
  input  logic             instr_valid,
  output logic             queue_full,
  input  logic             flush,
  output logic [UOP_W-1:0] disp_uop,
  output logic             disp_valid,
  input  logic             disp_ready,
  output logic [PTR_W:0]   occupancy,
  output logic             enq_err
);

  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [UOP_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             empty;
  logic             enq_req;
  logic             enq;
  logic             deq;

  assign empty      = (count == '0);
  // Full comes straight from the count register, so a same-cycle dequeue never unblocks rename.
  assign queue_full = (count == FULL_CNT);
  assign occupancy  = count;
  assign enq_req    = instr_valid & ~queue_full & ~flush;
  assign deq        = ~empty & disp_ready & ~flush;

`ifdef DISP_QUEUE_BYPASS_EN
  logic bypass;
  // An accepted bypass uop is consumed directly and never occupies a slot.
  assign bypass     = empty & instr_valid & ~flush;
  assign enq        = enq_req & ~(bypass & disp_ready);
  assign disp_valid = ~empty | bypass;
  assign disp_uop   = empty ? instr_uop : mem[rd_ptr];
`else
  assign enq        = enq_req;
  assign disp_valid = ~empty;
  assign disp_uop   = mem[rd_ptr];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      enq_err <= 1'b0;
    end else begin
      if (instr_valid & queue_full) enq_err <= 1'b1;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (enq) wr_ptr <= wr_ptr + PTR_ONE;
        if (deq) rd_ptr <= rd_ptr + PTR_ONE;
        unique case ({enq, deq})
          2'b10:   count <= count + CNT_ONE;
          2'b01:   count <= count - CNT_ONE;
          default: count <= count;
        endcase
      end
    end
  end

  // Payload storage needs no reset; valid tracking lives entirely in count.
  always_ff @(posedge clk) begin
    if (enq) mem[wr_ptr] <= instr_uop;
  end

endmodule

// File: tb/tb_dispatch_queue.sv
// Directed bench for dispatch_queue (DEPTH=8): ordered-queue scoreboard with a decoupled output monitor.
module tb_dispatch_queue;

  localparam int DEPTH = 8;
  localparam int UOP_W = 32;
`ifdef DISP_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic [UOP_W-1:0] instr_uop;
  logic             instr_valid;
  logic             queue_full;
  logic             flush;
  logic [UOP_W-1:0] disp_uop;
  logic             disp_valid;
  logic             disp_ready;
  logic [3:0]       occupancy;
  logic             enq_err;

  logic [UOP_W-1:0] exp_q[$];
  int               errors = 0;
  int               checks = 0;
  bit               rand_ready = 1'b0;

  dispatch_queue #(.DEPTH(DEPTH), .UOP_W(UOP_W)) dut (
    .clk(clk), .rst(rst), .instr_uop(instr_uop), .instr_valid(instr_valid),
    .queue_full(queue_full), .flush(flush), .disp_uop(disp_uop),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .occupancy(occupancy),
    .enq_err(enq_err)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required finish earlier");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [UOP_W-1:0] mk(input logic [7:0] tag);
    return {tag, ~tag, tag ^ 8'hA5, 8'h3C};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic enq_one(input logic [7:0] tag);
    instr_uop   = mk(tag);
    instr_valid = 1'b1;
    exp_q.push_back(mk(tag));
    step();
    instr_valid = 1'b0;
  endtask

  task automatic wait_not_full();
    int n = 0;
    while (queue_full && n < 200) begin
      step();
      n++;
    end
    if (queue_full) check("wait_not_full_timeout", 32'(queue_full), 32'd0);
  endtask

  task automatic drain(input string name);
    int n = 0;
    disp_ready = 1'b1;
    while (occupancy != 0 && n < 100) begin
      step();
      n++;
    end
    disp_ready = 1'b0;
    check({name, "_occ_zero"}, 32'(occupancy), 32'd0);
    check({name, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  // random backend stall generator
  always @(posedge clk) begin
    if (rand_ready) begin
      #1;
      disp_ready = 1'($urandom_range(0, 1));
    end
  end

  // scoreboard monitor: every accepted dispatch must match the oldest expected uop
  always @(negedge clk) begin
    if (!rst && disp_valid && disp_ready && !flush) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL disp_order: got 0x%0h, expected no dispatch (queue empty) at %0t", disp_uop, $time);
      end else begin
        logic [UOP_W-1:0] e;
        e = exp_q.pop_front();
        if (disp_uop !== e) begin
          errors++;
          $display("FAIL disp_order: got 0x%0h, expected 0x%0h at %0t", disp_uop, e, $time);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; instr_uop = '0; instr_valid = 1'b0; flush = 1'b0; disp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_occupancy", 32'(occupancy), 32'd0);
    check("rst_disp_valid", 32'(disp_valid), 32'd0);
    check("rst_queue_full", 32'(queue_full), 32'd0);
    check("rst_enq_err", 32'(enq_err), 32'd0);
    rst = 1'b0;
    step();

    // fill with backend stalled, then overflow attempt
    enq_one(8'd0);
    check("fill_first_valid", 32'(disp_valid), 32'd1);
    check("fill_first_occ", 32'(occupancy), 32'd1);
    for (int i = 1; i < 8; i++) enq_one(8'(i));
    check("fill_full", 32'(queue_full), 32'd1);
    check("fill_occ8", 32'(occupancy), 32'd8);
    instr_uop = mk(8'h99); instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
    check("ovf_enq_err", 32'(enq_err), 32'd1);
    check("ovf_occ8", 32'(occupancy), 32'd8);

    // full with simultaneous enq+deq: dequeue only
    instr_uop = mk(8'hA0); instr_valid = 1'b1; disp_ready = 1'b1;
    step();
    instr_valid = 1'b0; disp_ready = 1'b0;
    check("fullsim_occ7", 32'(occupancy), 32'd7);
    check("fullsim_not_full", 32'(queue_full), 32'd0);
    enq_one(8'd8);
    check("fullsim_refill_occ8", 32'(occupancy), 32'd8);
    drain("fullsim");

    // order and pointer wrap under random stalls
    rand_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      wait_not_full();
      enq_one(8'(i));
    end
    rand_ready = 1'b0;
    step();
    drain("order");
    check("enq_err_sticky", 32'(enq_err), 32'd1);

    // flush with same-cycle enq and deq requests
    for (int i = 0; i < 5; i++) enq_one(8'(8'h40 + i));
    check("flush_pre_occ5", 32'(occupancy), 32'd5);
    instr_uop = mk(8'h50); instr_valid = 1'b1; disp_ready = 1'b1; flush = 1'b1;
    step();
    flush = 1'b0; instr_valid = 1'b0; disp_ready = 1'b0;
    exp_q.delete();
    check("flush_occ0", 32'(occupancy), 32'd0);
    check("flush_disp_valid", 32'(disp_valid), 32'd0);
    check("flush_not_full", 32'(queue_full), 32'd0);
    enq_one(8'h51);
    check("flush_next_valid", 32'(disp_valid), 32'd1);
    check("flush_next_uop", disp_uop, mk(8'h51));
    drain("flush");

    // asynchronous reset between edges
    for (int i = 0; i < 6; i++) enq_one(8'(8'h60 + i));
    check("arst_pre_occ6", 32'(occupancy), 32'd6);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("arst_disp_valid", 32'(disp_valid), 32'd0);
    check("arst_queue_full", 32'(queue_full), 32'd0);
    check("arst_occ", 32'(occupancy), 32'd0);
    check("arst_enq_err", 32'(enq_err), 32'd0);
    exp_q.delete();
    #2;
    rst = 1'b0;
    step();

    // empty queue, uop offered with backend ready
    instr_uop = mk(8'h7E); instr_valid = 1'b1; disp_ready = 1'b1;
    exp_q.push_back(mk(8'h7E));
    #1;
    check("byp_same_cycle_valid", 32'(disp_valid), BYP ? 32'd1 : 32'd0);
    if (BYP) check("byp_same_cycle_uop", disp_uop, mk(8'h7E));
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    check("byp_next_occ", 32'(occupancy), BYP ? 32'd0 : 32'd1);
    check("byp_next_valid", 32'(disp_valid), BYP ? 32'd0 : 32'd1);
    drain("byp");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
